// File: rtl/secuenciador_rtc.sv
// secuenciador_rtc: drives control_salida with a power-up control write, periodic RTC
// register scans and single user writes. Define SEQ_TIMEOUT_EN to add the bus watchdog.
module secuenciador_rtc #(
  parameter int unsigned REFRESH_CYCLES = 1000000,
  parameter logic [7:0]  CTRL_ADDR      = 8'h02,
  parameter logic [7:0]  CTRL_DATA      = 8'h10,
  parameter int unsigned TO_CYCLES      = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fin,
  input  logic       escreg,
  input  logic [7:0] dato_in,
  input  logic       wr_req,
  input  logic [7:0] wr_dir,
  input  logic [7:0] wr_dato,
  output logic       iniciar,
  output logic       escribe,
  output logic [7:0] direccion,
  output logic [7:0] dato,
  output logic       wr_ack,
  output logic       ocupado,
  output logic       scan_done,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic [7:0] tseg,
  output logic [7:0] tmin,
  output logic [7:0] thora,
  output logic       error,
  output logic [2:0] estado_dbg
);

  // Bus handshake: iniciar is a level "valid"; direccion, dato and escribe are held with
  // it and only change after fin (control_salida's final pulse, renamed because final
  // is a reserved word) has been sampled; iniciar then drops for one GAP cycle.

  localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  if (REFRESH_CYCLES < 2) begin : g_chk_refresh
    $error("secuenciador_rtc: REFRESH_CYCLES must be at least 2");
  end
  if (TO_CYCLES < 1) begin : g_chk_timeout
    $error("secuenciador_rtc: TO_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_ESPERA = 3'd1,
    S_LECT   = 3'd2,
    S_ESCR   = 3'd3,
    S_GAP    = 3'd4
  } estado_t;

  estado_t          estado_q, estado_d;
  estado_t          destino_q, destino_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic             pend_q, pend_d;
  logic [7:0]       wdir_q, wdir_d;
  logic [7:0]       wdato_q, wdato_d;
  logic             iniciar_d, escribe_d, wr_ack_d, scan_done_d;
  logic [7:0]       direccion_d, dato_d;
  logic [7:0]       slot_q [0:8];
  logic             wr_acc;
  logic             to_hit;
  logic             fin_ev;

  function automatic logic [7:0] dir_tabla(input logic [3:0] i);
    case (i)
      4'd0:    dir_tabla = 8'h21;
      4'd1:    dir_tabla = 8'h22;
      4'd2:    dir_tabla = 8'h23;
      4'd3:    dir_tabla = 8'h24;
      4'd4:    dir_tabla = 8'h25;
      4'd5:    dir_tabla = 8'h26;
      4'd6:    dir_tabla = 8'h41;
      4'd7:    dir_tabla = 8'h42;
      4'd8:    dir_tabla = 8'h43;
      default: dir_tabla = 8'h21;
    endcase
  endfunction

  assign ocupado    = pend_q | (estado_q != S_ESPERA);
  assign wr_acc     = wr_req & ~ocupado;
  assign fin_ev     = iniciar & (fin | to_hit);
  assign estado_dbg = estado_q;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TO_CYCLES) + 1;
  logic [WD_W-1:0] wd_q;
  logic            err_q;

  assign to_hit = iniciar & (wd_q == WD_W'(TO_CYCLES - 1));
  assign error  = err_q;

  // wd_q counts cycles since iniciar rose; it is zero on the first high cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (!iniciar) wd_q <= '0;
      else          wd_q <= wd_q + 1'b1;
      if (to_hit && !fin) err_q <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign error  = 1'b0;
`endif

  always_comb begin
    estado_d    = estado_q;
    destino_d   = destino_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    wdir_d      = wdir_q;
    wdato_d     = wdato_q;
    iniciar_d   = iniciar;
    escribe_d   = escribe;
    direccion_d = direccion;
    dato_d      = dato;
    wr_ack_d    = 1'b0;
    scan_done_d = 1'b0;

    if (wr_acc) begin
      pend_d  = 1'b1;
      wdir_d  = wr_dir;
      wdato_d = wr_dato;
    end

    case (estado_q)
      S_INIT: begin
        if (!iniciar) begin
          iniciar_d   = 1'b1;
          escribe_d   = 1'b1;
          direccion_d = CTRL_ADDR;
          dato_d      = CTRL_DATA;
        end else if (fin_ev) begin
          iniciar_d = 1'b0;
          destino_d = S_ESPERA;
          estado_d  = S_GAP;
        end
      end
      S_ESPERA: begin
        // A pending write wins over expiry; the counter then holds at its last value
        // so the scan starts as soon as the write has finished.
        if (pend_d) begin
          estado_d    = S_ESCR;
          iniciar_d   = 1'b1;
          escribe_d   = 1'b1;
          direccion_d = wdir_d;
          dato_d      = wdato_d;
          if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          idx_d       = 4'd0;
          estado_d    = S_LECT;
          iniciar_d   = 1'b1;
          escribe_d   = 1'b0;
          direccion_d = dir_tabla(4'd0);
          dato_d      = 8'h00;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LECT: begin
        if (fin_ev) begin
          iniciar_d = 1'b0;
          estado_d  = S_GAP;
          if (idx_q == 4'd8) begin
            scan_done_d = 1'b1;
            destino_d   = S_ESPERA;
          end else begin
            idx_d     = idx_q + 4'd1;
            destino_d = S_LECT;
          end
        end
      end
      S_ESCR: begin
        if (fin_ev) begin
          iniciar_d = 1'b0;
          wr_ack_d  = 1'b1;
          pend_d    = 1'b0;
          destino_d = S_ESPERA;
          estado_d  = S_GAP;
        end
      end
      S_GAP: begin
        estado_d = destino_q;
        if (destino_q == S_LECT) begin
          iniciar_d   = 1'b1;
          escribe_d   = 1'b0;
          direccion_d = dir_tabla(idx_q);
          dato_d      = 8'h00;
        end
      end
      default: estado_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= S_INIT;
      destino_q <= S_ESPERA;
      cnt_q     <= '0;
      idx_q     <= 4'd0;
      pend_q    <= 1'b0;
      wdir_q    <= 8'h00;
      wdato_q   <= 8'h00;
      iniciar   <= 1'b0;
      escribe   <= 1'b0;
      direccion <= 8'h00;
      dato      <= 8'h00;
      wr_ack    <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      destino_q <= destino_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      wdir_q    <= wdir_d;
      wdato_q   <= wdato_d;
      iniciar   <= iniciar_d;
      escribe   <= escribe_d;
      direccion <= direccion_d;
      dato      <= dato_d;
      wr_ack    <= wr_ack_d;
      scan_done <= scan_done_d;
    end
  end

  // Read capture: the last escreg sample of a read wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) slot_q[i] <= 8'h00;
    end else if (estado_q == S_LECT && escreg) begin
      slot_q[idx_q] <= dato_in;
    end
  end

  assign seg   = slot_q[0];
  assign min   = slot_q[1];
  assign hora  = slot_q[2];
  assign dia   = slot_q[3];
  assign mes   = slot_q[4];
  assign anio  = slot_q[5];
  assign tseg  = slot_q[6];
  assign tmin  = slot_q[7];
  assign thora = slot_q[8];

endmodule

// File: tb/tb_secuenciador_rtc.sv
// Self-checking bench for secuenciador_rtc with a behavioural control_salida model.
module tb_secuenciador_rtc;

  localparam int unsigned REFRESH = 200;
  localparam int unsigned TO_CYC  = 64;
  localparam int W_FIN  = 0;
  localparam int W_INI  = 1;
  localparam int W_DONE = 2;
  localparam int W_ACK  = 3;
  localparam int W_IDX4 = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       fin, escreg;
  logic [7:0] dato_in;
  logic       wr_req;
  logic [7:0] wr_dir, wr_dato;
  logic       iniciar, escribe, wr_ack, ocupado, scan_done, error;
  logic [7:0] direccion, dato;
  logic [7:0] seg, min, hora, dia, mes, anio, tseg, tmin, thora;
  logic [2:0] estado_dbg;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [16:0] exp_q[$];
  logic [7:0]  rd_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

  bit         hold_final = 1'b0;
  bit         m_busy, m_wr, m_unstable;
  int         m_cnt;
  logic [7:0] m_addr, m_dato;

  secuenciador_rtc #(
    .REFRESH_CYCLES(REFRESH),
    .CTRL_ADDR(8'h02),
    .CTRL_DATA(8'h10),
    .TO_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .reset(reset), .fin(fin), .escreg(escreg), .dato_in(dato_in),
    .wr_req(wr_req), .wr_dir(wr_dir), .wr_dato(wr_dato),
    .iniciar(iniciar), .escribe(escribe), .direccion(direccion), .dato(dato),
    .wr_ack(wr_ack), .ocupado(ocupado), .scan_done(scan_done),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
    .tseg(tseg), .tmin(tmin), .thora(thora), .error(error), .estado_dbg(estado_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      W_FIN:   return fin === 1'b1;
      W_INI:   return iniciar === 1'b1;
      W_DONE:  return scan_done === 1'b1;
      W_ACK:   return wr_ack === 1'b1;
      W_IDX4:  return (iniciar === 1'b1) && (direccion === 8'h25);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cond(sel)) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  function automatic logic [7:0] reg_val(input int i);
    case (i)
      0: return seg;   1: return min;  2: return hora;
      3: return dia;   4: return mes;  5: return anio;
      6: return tseg;  7: return tmin; 8: return thora;
      default: return 8'hxx;
    endcase
  endfunction

  task automatic push_scan();
    for (int i = 0; i < 9; i++) exp_q.push_back({1'b0, rd_addr[i], 8'h00});
  endtask

  task automatic txn_start(input logic [16:0] obs);
    n_asserts++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL txn_unexpected: observed %0h expected none", obs);
    end
    if (exp_q.size() > 0) check("txn_order", obs, exp_q.pop_front());
  endtask

  // control_salida model: 29-cycle transactions, escreg on cycles 10..12 of a read
  // (only the last sample carries addr+1), final pulse at cycle 28, abort on iniciar=0.
  initial begin
    fin = 1'b0; escreg = 1'b0; dato_in = 8'h00; m_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        m_busy = 1'b0; fin = 1'b0; escreg = 1'b0;
      end else if (!m_busy) begin
        fin = 1'b0; escreg = 1'b0; dato_in = 8'($urandom);
        if (iniciar === 1'b1) begin
          m_busy = 1'b1; m_cnt = 0; m_unstable = 1'b0;
          m_addr = direccion; m_dato = dato; m_wr = escribe;
          txn_start({escribe, direccion, dato});
        end
      end else if (iniciar !== 1'b1) begin
        m_busy = 1'b0; fin = 1'b0; escreg = 1'b0;
      end else begin
        m_cnt++;
        if ({escribe, direccion, dato} !== {m_wr, m_addr, m_dato}) m_unstable = 1'b1;
        escreg  = !hold_final && !m_wr && (m_cnt >= 10) && (m_cnt <= 12);
        dato_in = (m_cnt == 12) ? m_addr + 8'd1 : 8'($urandom);
        if (!hold_final && m_cnt >= 28 && !fin) begin
          fin = 1'b1;
          check("txn_stable", m_unstable, 0);
        end
      end
    end
  end

  // directed sequence
  initial begin
    int n;
    logic [7:0] d, v;
    reset = 1'b1; wr_req = 1'b0; wr_dir = 8'h00; wr_dato = 8'h00;
    repeat (3) tick();

    check("rst_iniciar", iniciar, 0);
    check("rst_escribe", escribe, 0);
    check("rst_direccion", direccion, 0);
    check("rst_dato", dato, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_error", error, 0);
    for (int i = 0; i < 9; i++) check("rst_reg", reg_val(i), 0);

    // 1: power-up control write
    exp_q.push_back({1'b1, 8'h02, 8'h10});
    reset = 1'b0;
    tick();
    check("init_iniciar", iniciar, 1);
    check("init_word", {escribe, direccion, dato}, {1'b1, 8'h02, 8'h10});
    wait_for(W_FIN, 100, "init_fin_wait");
    check("init_iniciar_fall", iniciar, 0);

    // 2: first scan after one GAP cycle plus REFRESH idle cycles
    push_scan();
    n = 0;
    do begin
      tick();
      n++;
      if (n == 2) check("espera_ocupado", ocupado, 0);
    end while (iniciar !== 1'b1 && n < 1000);
    check("refresh_interval", n, REFRESH + 1);
    check("scan_first_word", {escribe, direccion, dato}, {1'b0, 8'h21, 8'h00});
    check("scan_ocupado", ocupado, 1);

    // request while busy is dropped
    wr_req = 1'b1; wr_dir = 8'($urandom); wr_dato = 8'($urandom);
    tick();
    wr_req = 1'b0;
    wait_for(W_FIN, 100, "rd0_fin_wait");
    check("gap_low", iniciar, 0);
    tick();
    check("gap_one_cycle", iniciar, 1);
    check("rd1_dir", direccion, 8'h22);
    wait_for(W_DONE, 600, "scan1_done_wait");
    tick();
    check("scan_done_pulse", scan_done, 0);
    for (int i = 0; i < 9; i++) check("scan1_reg", reg_val(i), rd_addr[i] + 8'd1);

    // 4: write request on the refresh expiry cycle goes first
    repeat (REFRESH - 1) tick();
    d = 8'($urandom_range(0, 255)); v = 8'($urandom_range(0, 255));
    exp_q.push_back({1'b1, d, v});
    push_scan();
    wr_req = 1'b1; wr_dir = d; wr_dato = v;
    tick();
    wr_req = 1'b0;
    check("expiry_write_first", {iniciar, escribe, direccion, dato}, {1'b1, 1'b1, d, v});
    wait_for(W_ACK, 100, "expiry_ack_wait");
    tick();
    check("expiry_ack_pulse", wr_ack, 0);
    wait_for(W_DONE, 700, "scan2_done_wait");

    // 3: served user write, second request while busy ignored
    check("post_scan_ocupado", ocupado, 1);
    tick();
    check("idle_ocupado", ocupado, 0);
    exp_q.push_back({1'b1, 8'h23, 8'h59});
    wr_req = 1'b1; wr_dir = 8'h23; wr_dato = 8'h59;
    tick();
    check("user_write_word", {iniciar, escribe, direccion, dato}, {1'b1, 1'b1, 8'h23, 8'h59});
    check("user_write_ocupado", ocupado, 1);
    wr_dir = 8'($urandom); wr_dato = 8'($urandom);
    tick();
    wr_req = 1'b0;
    wait_for(W_ACK, 100, "user_ack_wait");
    tick();
    check("user_ack_pulse", wr_ack, 0);
    check("second_req_dropped", ocupado, 0);
    push_scan();

    // 5: reset in the middle of the idx 4 read
    wait_for(W_IDX4, 1500, "idx4_wait");
    reset = 1'b1;
    tick();
    check("midreset_iniciar", iniciar, 0);
    check("midreset_word", {escribe, direccion, dato}, 0);
    for (int i = 0; i < 9; i++) check("midreset_reg", reg_val(i), 0);
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h02, 8'h10});
    tick();
    reset = 1'b0;
    tick();
    check("reinit_word", {iniciar, escribe, direccion, dato}, {1'b1, 1'b1, 8'h02, 8'h10});
    wait_for(W_FIN, 100, "reinit_fin_wait");

    // 6: final withheld on the first read of the next scan
    push_scan();
    hold_final = 1'b1;
    wait_for(W_INI, 400, "hold_ini_wait");
`ifdef SEQ_TIMEOUT_EN
    n = 0;
    do begin
      tick();
      n++;
    end while (iniciar === 1'b1 && n < 200);
    check("timeout_len", n, TO_CYC);
    check("timeout_error", error, 1);
    hold_final = 1'b0;
    tick();
    check("timeout_continue", {iniciar, direccion}, {1'b1, 8'h22});
`else
    repeat (150) tick();
    check("no_timeout_iniciar", {iniciar, direccion}, {1'b1, 8'h21});
    check("no_timeout_error", error, 0);
    hold_final = 1'b0;
`endif
    wait_for(W_DONE, 800, "scan_after_hold_wait");
    check("held_slot_unchanged", seg, 0);
    for (int i = 1; i < 9; i++) check("scan_after_hold_reg", reg_val(i), rd_addr[i] + 8'd1);
`ifdef SEQ_TIMEOUT_EN
    check("error_sticky", error, 1);
`else
    check("error_tied", error, 0);
`endif
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
